// File: rtl/rv32i_types.sv
// Shared pipeline types: the inter-stage word bundle and stage_queue helpers.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
    } rv32i_stage;

    localparam int STAGEQ_DEFAULT_DEPTH = 2;

    // Encoded as {write, read-advance} so the pair can be cast directly.
    typedef enum logic [1:0] {
        SQ_IDLE = 2'b00,
        SQ_POP  = 2'b01,
        SQ_PUSH = 2'b10,
        SQ_BOTH = 2'b11
    } stageq_op_e;

    function automatic int stageq_ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stage_queue_if.sv
// Valid/ready bundle between an upstream stage, the queue and a downstream stage.
interface stage_queue_if
    import rv32i_types::*;
#(
    parameter int WIDTH = $bits(rv32i_stage)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stage_queue_mem.sv
// Entry storage for stage_queue: one write port, one asynchronous read port, no reset.
module stage_queue_mem
    import rv32i_types::*;
#(
    parameter int WIDTH = $bits(rv32i_stage),
    parameter int DEPTH = STAGEQ_DEFAULT_DEPTH,
    parameter int PTR_W = stageq_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write only on an accepted push so unread entries stay stable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/stage_queue.sv
// Elastic inter-stage queue: circular buffer with valid/ready on both sides,
// synchronous flush, almost-full watermark and optional empty-queue bypass.
module stage_queue
    import rv32i_types::*;
#(
    parameter  int WIDTH       = $bits(rv32i_stage),
    parameter  int DEPTH       = STAGEQ_DEFAULT_DEPTH,
    parameter  int BYPASS      = 0,
    parameter  int AFULL_LEVEL = DEPTH - 1,
    localparam int PTR_W       = stageq_ptr_w(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    stage_queue_if.slave     bus,
    output logic [CNT_W-1:0] count,
    output logic             almost_full
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LEVEL);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    generate
        if (DEPTH < 1 || AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_param
            $fatal(1, "stage_queue: DEPTH must be >=1 and AFULL_LEVEL in 1..DEPTH");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic             almost_full_r, almost_full_next_s;
    logic             empty_s, bypass_s, in_ready_s, out_valid_s;
    logic             push_s, pop_s, bypass_xfer_s, wr_en_s, rd_adv_s;
    logic [WIDTH-1:0] rd_data_s, out_data_s;
    stageq_op_e       op_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    stage_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Handshake decode; a bypass transfer neither writes storage nor moves pointers.
    always_comb begin
        empty_s       = (count_r == {CNT_W{1'b0}});
        bypass_s      = (BYPASS != 0) && empty_s;
        in_ready_s    = !flush && (count_r < DEPTH_C);
        out_valid_s   = !flush && (!empty_s || (bypass_s && bus.in_valid));
        push_s        = bus.in_valid && in_ready_s;
        pop_s         = out_valid_s && bus.out_ready;
        bypass_xfer_s = bypass_s && pop_s;
        wr_en_s       = push_s && !bypass_xfer_s;
        rd_adv_s      = pop_s && !bypass_xfer_s;
        if (!out_valid_s) begin
            out_data_s = {WIDTH{1'b0}};
        end else if (empty_s) begin
            out_data_s = bus.in_data;
        end else begin
            out_data_s = rd_data_s;
        end
    end

    // Next pointers, occupancy and watermark; flush wins over any transfer.
    always_comb begin
        op_s          = stageq_op_e'({wr_en_s, rd_adv_s});
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (flush) begin
            wr_ptr_next_s = {PTR_W{1'b0}};
            rd_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else begin
            case (op_s)
                SQ_PUSH: begin
                    wr_ptr_next_s = ptr_inc(wr_ptr_r);
                    count_next_s  = count_r + CNT_W'(1);
                end
                SQ_POP: begin
                    rd_ptr_next_s = ptr_inc(rd_ptr_r);
                    count_next_s  = count_r - CNT_W'(1);
                end
                SQ_BOTH: begin
                    wr_ptr_next_s = ptr_inc(wr_ptr_r);
                    rd_ptr_next_s = ptr_inc(rd_ptr_r);
                end
                SQ_IDLE: begin
                    count_next_s = count_r;
                end
                default: begin
                    count_next_s = count_r;
                end
            endcase
        end
        almost_full_next_s = (count_next_s >= AFULL_C);
    end

    // Control state registers; storage is intentionally left out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            almost_full_r <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_next_s;
            rd_ptr_r      <= rd_ptr_next_s;
            count_r       <= count_next_s;
            almost_full_r <= almost_full_next_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign count         = count_r;
    assign almost_full   = almost_full_r;

endmodule

// File: doc/stage_queue.md
Name: stage_queue

Overview:
- Parametrised, elastic replacement for the fixed single-entry inter-stage register that carries the rv32i_stage control/data word bundle between pipeline stages.
- Holds up to DEPTH stage words in a circular buffer with valid/ready handshakes on both sides, a synchronous flush for branch/jump squash, and an almost-full watermark.
- Optional same-cycle bypass when empty.
- Placed between any two stages (e.g. decode->execute, execute->memory) that need decoupling or skid capacity.

Parameters:
- WIDTH, $bits(rv32i_types::rv32i_stage): payload width in bits.
- DEPTH, 2: number of entries, >=1, need not be a power of two.
- BYPASS, 0: 1 means an empty queue passes in_data to out_data combinationally in the same cycle.
- AFULL_LEVEL, DEPTH-1: occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all entries and of the current input
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  queue accepts this cycle
- in_data  in  WIDTH  stage word from upstream
- out_valid  out  1  out_data holds the oldest entry
- out_ready  in  1  downstream consumes this cycle
- out_data  out  WIDTH  oldest stage word; all zero when out_valid=0
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  count >= AFULL_LEVEL

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, almost_full=0, in_ready=1 unless flush is asserted.
  - Storage contents are not reset.
- Transfers:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - Both evaluated on the same rising edge.
- in_ready = !flush & (count < DEPTH). It has no combinational dependence on out_ready, so a full queue refuses input even when popping that cycle.
- out_valid:
  - BYPASS=0: out_valid = !flush & (count != 0).
  - BYPASS=1: out_valid = !flush & ((count != 0) | in_valid).
- Latency:
  - BYPASS=0: word pushed at edge N is visible at out_data after edge N, i.e. 1 cycle.
  - BYPASS=1 with count=0: in_data appears the same cycle. If out_ready=1, the word is consumed and not written; pointers and count are unchanged. If out_ready=0, the word is written normally.
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance and count is unchanged.
- Pointers are $clog2(DEPTH) bits, minimum 1. They wrap from DEPTH-1 to 0 explicitly, never by natural overflow.
- Ordering is strict FIFO; no entry is duplicated or reordered.
- flush:
  - Pointers and count go to 0 at the next edge.
  - In the flush cycle in_ready=0 and out_valid=0, so no push or pop occurs.
  - flush overrides every other input, including a bypass transfer.
- count:
  - +1 on push only, -1 on pop only, unchanged otherwise.
  - Never exceeds DEPTH and never underflows.
  - A pop while empty is impossible because out_valid=0 (BYPASS=0).
- almost_full is a registered compare of the next count, so it is valid in the same cycle as count.
- Storage writes occur only on push, so data for entries not yet popped is stable.
- Parameter elaboration checks DEPTH>=1 and 1<=AFULL_LEVEL<=DEPTH; a violation is a fatal error.

Decomposition:
- Shared package rv32i_types gains:
  - typedef rv32i_stage (already present), whose $bits sets the WIDTH default.
  - localparam STAGEQ_DEFAULT_DEPTH = 2.
  - A function stageq_ptr_w(depth) returning max(1,$clog2(depth)).
- Natural sub-module: stage_queue_mem.
  - DEPTH x WIDTH register array with one write port and one asynchronous read port, no reset.
  - The queue control FSM (pointers, count, flush, bypass) stays in stage_queue.

Test Plan:
- Reset mid-operation: fill 2 entries (DEPTH=4), drop rst_n asynchronously between edges -> count=0, out_valid=0, almost_full=0 immediately; in_ready=1 after release.
- Fill to full, DEPTH=3, AFULL_LEVEL=2: push 0xA,0xB,0xC with out_ready=0 -> count 1,2,3; almost_full rises with count=2; in_ready=0 at count=3. A fourth offer 0xD is not accepted. Draining returns 0xA,0xB,0xC in order, and out_data=0 after the last pop.
- Wrap-around, DEPTH=3: 10 words 1..10, one push and one pop per cycle after priming one entry -> outputs 1..10 in order, count held at 1, pointers wrap 2->0 without error.
- Full plus pop, DEPTH=2: with count=2, assert in_valid and out_ready together -> pop occurs, no push, count=1 next cycle.
- Flush: 3 entries queued with in_valid=1 and flush=1 -> in_ready=0 and out_valid=0 that cycle, count=0 after the edge, flushed words never appear at out_data.
- Bypass, BYPASS=1 and empty: in_data=0x55AA with out_ready=1 -> out_valid=1 and out_data=0x55AA the same cycle, count stays 0. Repeat with out_ready=0 -> count=1, and 0x55AA is still presented next cycle.
